// File: rtl/seq_gen_pkg.sv
// Shared types and defaults for the serial frame transmitter.
package seq_pkg;

   // Transmitter phases: idle, sync pattern, payload, inter-frame gap.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   localparam int         SYNC_W_DEF   = 4;
   localparam logic [3:0] SYNC_PAT_DEF = 4'b1011;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Counter must hold every per-state cycle index without wrapping.
   function automatic int cnt_width(input int a, input int b, input int c);
      int w;
      w = $clog2(max3(a, b, c) + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/seq_gen_if.sv
// Payload handshake and serial output bundle of the frame transmitter.
//
// Handshake: a payload transfers at a rising edge where load and ready are
// both high. ready is registered and never depends on load in the same cycle;
// load while ready is low is ignored and data_in is not sampled.
interface seq_gen_if #(
   parameter int DATA_W = 8
);
   import seq_pkg::*;

   logic              load;
   logic [DATA_W-1:0] data_in;
   logic              ready;
   logic              out;
   logic              out_valid;
   logic              frame_start;
   logic              done;
   state_t            state_dbg;

   // Payload source and serial line observer.
   modport master (
      output load,
      output data_in,
      input  ready,
      input  out,
      input  out_valid,
      input  frame_start,
      input  done,
      input  state_dbg
   );

   // The transmitter itself.
   modport slave (
      input  load,
      input  data_in,
      output ready,
      output out,
      output out_valid,
      output frame_start,
      output done,
      output state_dbg
   );

endinterface

// File: rtl/seq_gen_piso.sv
// Parallel-in / serial-out register: load wins over shift, MSB is the serial tap.
module piso_shift #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] d,
   output logic         msb
);

   logic [W-1:0] sh_q;

   // Capture a new word or move the remaining bits one place toward the MSB.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_q <= '0;
      end else if (load) begin
         sh_q <= d;
      end else if (shift) begin
         sh_q <= sh_q << 1;
      end
   end

   assign msb = sh_q[W-1];

endmodule

// File: rtl/seq_gen.sv
// Serial frame transmitter: sync pattern, then payload MSB first, then an
// idle gap. Every output is a flop; the next output values are derived from
// the next state so each bit appears exactly in the cycle its state covers.
module seq_gen
   import seq_pkg::*;
#(
   parameter int                SYNC_W   = SYNC_W_DEF,
   parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF,
   parameter int                DATA_W   = 8,
   parameter int                GAP      = 1,
   parameter logic              IDLE_BIT = 1'b0
) (
   input logic      clk,
   input logic      rst,
   seq_gen_if.slave bus
);

   localparam int CNT_W = cnt_width(SYNC_W, DATA_W, GAP);

   // Last cycle index inside each counted state.
   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? (GAP - 1) : 0);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic accept;
   logic sh_load, sh_shift, sh_msb;

   logic out_q, out_d;
   logic valid_q, valid_d;
   logic fs_q, fs_d;
   logic done_q, done_d;
   logic ready_q, ready_d;

   assign accept = bus.load && ready_q;

   // Payload holder; its MSB is the payload bit due on the line next.
   piso_shift #(
      .W (DATA_W)
   ) u_piso (
      .clk   (clk),
      .rst   (rst),
      .load  (sh_load),
      .shift (sh_shift),
      .d     (bus.data_in),
      .msb   (sh_msb)
   );

   // State and per-state cycle counter; the counter restarts on every state change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: state_q/cnt_q describe the bit currently on the line.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SYNC;
               cnt_d   = '0;
            end
         end
         ST_SYNC: begin
            if (cnt_q == SYNC_LAST) begin
               state_d = ST_DATA;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt_q == DATA_LAST) begin
               state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Next output values, taken from the state the next cycle will be in.
   // The payload register shifts on the same edge its MSB is copied to out,
   // so the register always holds the bit for the following data cycle.
   always_comb begin
      out_d    = IDLE_BIT;
      valid_d  = 1'b0;
      fs_d     = accept;
      done_d   = 1'b0;
      ready_d  = (state_d == ST_IDLE);
      sh_load  = accept;
      sh_shift = 1'b0;
      case (state_d)
         ST_SYNC: begin
            valid_d = 1'b1;
            for (int i = 0; i < SYNC_W; i++) begin
               if (cnt_d == CNT_W'(SYNC_W - 1 - i)) begin
                  out_d = SYNC_PAT[i];
               end
            end
         end
         ST_DATA: begin
            valid_d  = 1'b1;
            out_d    = sh_msb;
            sh_shift = 1'b1;
            done_d   = (cnt_d == DATA_LAST);
         end
         default: begin
            out_d = IDLE_BIT;
         end
      endcase
   end

   // Output flops; reset leaves the line idle and ready low until the first edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q   <= IDLE_BIT;
         valid_q <= 1'b0;
         fs_q    <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
         fs_q    <= fs_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign bus.out         = out_q;
   assign bus.out_valid   = valid_q;
   assign bus.frame_start = fs_q;
   assign bus.done        = done_q;
   assign bus.ready       = ready_q;
   assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: default build (4-bit sync, 8-bit payload, gap 1) and a
// gap-0 / 4-bit payload build, checked every cycle against a phase model.
module tb_seq_gen;
   import seq_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   seq_gen_if #(.DATA_W(8)) bus1 ();
   seq_gen_if #(.DATA_W(4)) bus2 ();

   seq_gen u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   seq_gen #(
      .DATA_W (4),
      .GAP    (0)
   ) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   // ---------------- bookkeeping ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- model ----------------
   // Phase: -1 just reset, 0 idle+ready, 1..F frame bit number, F+1..F+G gap.
   function automatic int model_next(input int ph, input logic ld, input int f, input int g);
      if (ph == -1) return 0;
      if (ph == 0)  return ld ? 1 : 0;
      if (ph < f + g) return ph + 1;
      return 0;
   endfunction

   // Expected {ready, out, out_valid, frame_start, done} for a phase.
   function automatic logic [4:0] model_outs(input int ph, input logic [15:0] frame, input int f);
      logic b;
      if (ph == 0) return 5'b10000;
      if (ph < 0 || ph > f) return 5'b00000;
      b = frame[f - ph];
      return {1'b0, b, 1'b1, (ph == 1), (ph == f)};
   endfunction

   int          ph1 = -1, ph2 = -1;
   logic [15:0] fr1 = '0, fr2 = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         ph1 = -1;
         ph2 = -1;
      end else begin
         if (ph1 == 0 && bus1.load) fr1 = 16'({4'b1011, bus1.data_in});
         if (ph2 == 0 && bus2.load) fr2 = 16'({4'b1011, bus2.data_in});
         ph1 = model_next(ph1, bus1.load, 12, 1);
         ph2 = model_next(ph2, bus2.load, 8, 0);
      end
   end

   // ---------------- compare ----------------
   always @(negedge clk) begin
      logic [4:0] e1, e2;
      e1 = model_outs(ph1, fr1, 12);
      e2 = model_outs(ph2, fr2, 8);
      check("d1_ready",       32'(bus1.ready),       32'(e1[4]));
      check("d1_out",         32'(bus1.out),         32'(e1[3]));
      check("d1_out_valid",   32'(bus1.out_valid),   32'(e1[2]));
      check("d1_frame_start", 32'(bus1.frame_start), 32'(e1[1]));
      check("d1_done",        32'(bus1.done),        32'(e1[0]));
      check("d2_ready",       32'(bus2.ready),       32'(e2[4]));
      check("d2_out",         32'(bus2.out),         32'(e2[3]));
      check("d2_out_valid",   32'(bus2.out_valid),   32'(e2[2]));
      check("d2_frame_start", 32'(bus2.frame_start), 32'(e2[1]));
      check("d2_done",        32'(bus2.done),        32'(e2[0]));
   end

   // ---------------- scoreboard: whole frames vs hand-computed words ----------------
   logic [11:0] exp_q[$];
   logic [7:0]  exp2_q[$];
   int          fs_cyc[$];
   logic [11:0] cap1 = '0;
   logic [7:0]  cap2 = '0;
   int          n1 = 0, n2 = 0;

   always @(negedge clk) begin
      if (!rst) begin
         cap1 = '0;
         n1   = 0;
      end else if (bus1.out_valid) begin
         if (bus1.frame_start) fs_cyc.push_back(cyc);
         cap1 = {cap1[10:0], bus1.out};
         n1++;
         if (bus1.done) begin
            check("d1_frame_len", 32'(n1), 32'd12);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL d1_frame_unexpected @cyc %0d: got frame %0h expected none", cyc, cap1);
            end else begin
               check("d1_frame_bits", 32'(cap1), 32'(exp_q.pop_front()));
            end
            n1 = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         cap2 = '0;
         n2   = 0;
      end else if (bus2.out_valid) begin
         cap2 = {cap2[6:0], bus2.out};
         n2++;
         if (bus2.done) begin
            check("d2_frame_len", 32'(n2), 32'd8);
            if (exp2_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL d2_frame_unexpected @cyc %0d: got frame %0h expected none", cyc, cap2);
            end else begin
               check("d2_frame_bits", 32'(cap2), 32'(exp2_q.pop_front()));
            end
            n2 = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse1(input logic [7:0] d);
      bus1.data_in = d;
      bus1.load    = 1'b1;
      tick();
      bus1.load    = 1'b0;
   endtask

   task automatic wait_ready1(input string name);
      int k;
      k = 0;
      while (!bus1.ready && k < 60) begin
         tick();
         k++;
      end
      check(name, 32'(bus1.ready), 32'd1);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got no end of stimulus expected finish before 200000");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int k;
      bus1.load    = 1'b0;
      bus1.data_in = '0;
      bus2.load    = 1'b0;
      bus2.data_in = '0;
      rst          = 1'b0;

      // Reset then idle.
      repeat (3) tick();
      check("rst_out",       32'(bus1.out),       32'd0);
      check("rst_out_valid", 32'(bus1.out_valid), 32'd0);
      check("rst_ready",     32'(bus1.ready),     32'd0);
      check("rst_state",     32'(bus1.state_dbg), 32'(ST_IDLE));
      rst = 1'b1;
      tick();
      check("ready_after_release",  32'(bus1.ready), 32'd1);
      check("ready2_after_release", 32'(bus2.ready), 32'd1);

      // Single frame A5: 1011 1010 0101.
      exp_q.push_back(12'hBA5);
      pulse1(8'hA5);
      check("a5_first_bit",   32'(bus1.out),         32'd1);
      check("a5_frame_start", 32'(bus1.frame_start), 32'd1);
      repeat (11) tick();
      check("a5_done_last",   32'(bus1.done),        32'd1);
      check("a5_last_bit",    32'(bus1.out),         32'd1);
      tick();
      check("a5_gap_ready",   32'(bus1.ready),       32'd0);
      check("a5_gap_valid",   32'(bus1.out_valid),   32'd0);
      tick();
      check("a5_ready_back",  32'(bus1.ready),       32'd1);

      // Busy rejection: second load during the frame is ignored.
      exp_q.push_back(12'hBFF);
      pulse1(8'hFF);
      repeat (3) tick();
      bus1.data_in = 8'h00;
      bus1.load    = 1'b1;
      tick();
      bus1.load    = 1'b0;
      wait_ready1("busy_ready");
      repeat (3) tick();
      check("busy_no_second_frame", 32'(bus1.out_valid), 32'd0);

      // Back-to-back with load held high.
      fs_cyc.delete();
      exp_q.push_back(12'hB3C);
      exp_q.push_back(12'hBC3);
      bus1.data_in = 8'h3C;
      bus1.load    = 1'b1;
      tick();
      bus1.data_in = 8'hC3;
      k = 0;
      while (fs_cyc.size() < 2 && k < 40) begin
         tick();
         k++;
      end
      bus1.load = 1'b0;
      check("b2b_frames", 32'(fs_cyc.size()), 32'd2);
      if (fs_cyc.size() == 2) check("b2b_spacing", 32'(fs_cyc[1] - fs_cyc[0]), 32'd14);
      wait_ready1("b2b_ready");

      // Mid-frame reset during payload bit 3 (frame bit 7).
      pulse1(8'h5A);
      repeat (6) tick();
      rst = 1'b0;
      #1;
      check("midrst_valid", 32'(bus1.out_valid), 32'd0);
      check("midrst_out",   32'(bus1.out),       32'd0);
      check("midrst_done",  32'(bus1.done),      32'd0);
      tick();
      rst = 1'b1;
      tick();
      check("midrst_ready_back", 32'(bus1.ready), 32'd1);
      exp_q.push_back(12'hB5A);
      pulse1(8'h5A);
      check("after_rst_frame_start", 32'(bus1.frame_start), 32'd1);
      wait_ready1("after_rst_ready");

      // Gap-0, 4-bit payload build: 1011 1001.
      exp2_q.push_back(8'hB9);
      bus2.data_in = 4'h9;
      bus2.load    = 1'b1;
      tick();
      bus2.load    = 1'b0;
      check("g0_first_bit", 32'(bus2.out),   32'd1);
      repeat (7) tick();
      check("g0_done",      32'(bus2.done),  32'd1);
      check("g0_last_bit",  32'(bus2.out),   32'd1);
      check("g0_busy",      32'(bus2.ready), 32'd0);
      tick();
      check("g0_ready_next",  32'(bus2.ready),     32'd1);
      check("g0_valid_low",   32'(bus2.out_valid), 32'd0);

      repeat (3) tick();
      check("d1_frames_pending", 32'(exp_q.size()),  32'd0);
      check("d2_frames_pending", 32'(exp2_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
- Serial frame transmitter: the generating end of the team's serial "1011" sequence detector link.
- Accepts a parallel payload word through a valid/ready handshake.
- Emits, MSB first, one bit per clock: a fixed sync pattern (default 1011), then the payload bits, then a programmable idle gap.
- Drives the serial stimulus line into `seq_det`-style detectors and any downstream serial receiver.

Parameters:
- `SYNC_W`, 4: sync pattern width in bits (≥1).
- `SYNC_PAT`, 4'b1011: sync pattern, sent MSB first.
- `DATA_W`, 8: payload width in bits (≥1).
- `GAP`, 1: idle cycles after each frame before `ready` reasserts (≥0).
- `IDLE_BIT`, 1'b0: serial line value when not transmitting.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `load`  in  1  payload valid; accepted when `load && ready` at a rising edge.
- `data_in`  in  `DATA_W`  payload word; sampled only on acceptance.
- `ready`  out  1  block can accept a payload.
- `out`  out  1  serial bit, registered.
- `out_valid`  out  1  `out` carries a frame bit (sync or payload).
- `frame_start`  out  1  one-cycle pulse coincident with the first sync bit.
- `done`  out  1  one-cycle pulse coincident with the last payload bit.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - State goes to IDLE; counters clear.
  - Outputs: `out`=`IDLE_BIT`, `out_valid`=0, `frame_start`=0, `done`=0, `ready`=0.
  - `ready` rises at the first rising edge after `rst` is released.
- All outputs are registered; there is no combinational path from inputs to outputs.
- FSM states are IDLE, SYNC, DATA, GAP.
- IDLE:
  - `ready`=1; `out`=`IDLE_BIT`.
  - On `load && ready` at edge T: latch `data_in` into the shift register and go to SYNC.
  - After edge T: `ready`=0, `out`=`SYNC_PAT[SYNC_W-1]`, `out_valid`=1, `frame_start`=1.
  - Latency: first frame bit is visible in the cycle after acceptance.
- SYNC:
  - Emits `SYNC_PAT` MSB to LSB over `SYNC_W` cycles, counted by `bit_cnt`.
  - After the last sync bit, goes to DATA; the next cycle shows `data[DATA_W-1]`.
- DATA:
  - Emits the payload MSB first over `DATA_W` cycles by left shift.
  - `done`=1 during the cycle showing `data[0]`.
  - Next state is GAP if `GAP`>0, otherwise IDLE.
- GAP:
  - `out`=`IDLE_BIT`, `out_valid`=0, `ready`=0 for exactly `GAP` cycles, then IDLE.
- Frame timing:
  - `out_valid` is high for exactly `SYNC_W+DATA_W` consecutive cycles per frame.
  - Minimum spacing between acceptances is `SYNC_W+DATA_W+GAP+1` cycles.
  - `ready` returns high in the cycle after the last GAP cycle; with `GAP`=0, in the cycle after the last payload bit.
- Boundary conditions:
  - `load` while `ready`=0: ignored; `data_in` not sampled; no error flag.
  - `data_in` changes mid-frame: no effect on the transmitted bits.
  - `load` held high continuously: frames go back-to-back at minimum spacing, each payload taken at its own acceptance edge.
  - `rst` asserted mid-frame: frame aborted immediately; outputs take reset values; no `done` pulse.
  - Counter width is $clog2(max(`SYNC_W`,`DATA_W`,`GAP`)+1); the counter clears on every state change and never wraps within a state.

Decomposition:
- Package `seq_pkg`:
  - State enum (IDLE, SYNC, DATA, GAP).
  - Default constants `SYNC_PAT_DEF`=4'b1011, `SYNC_W_DEF`=4.
- Sub-module `piso_shift`:
  - Parameterised parallel-in/serial-out register; ports load, shift, `d`, msb.
  - Async active-low reset.
  - Used for the payload.
- Sync bits are indexed directly from the `SYNC_PAT` parameter; no sub-module.

Test Plan:
- Reset then idle: hold `rst`=0 for 3 cycles, release → `out`=0, `out_valid`=0, `ready`=0 during reset; `ready`=1 one edge after release.
- Single frame: `data_in`=8'hA5, `load` pulse → from the next cycle `out`=1,0,1,1,1,0,1,0,0,1,0,1 with `out_valid`=1 for 12 cycles; `frame_start` on bit 1; `done` on bit 12; `ready` back after 1 gap cycle.
- Busy rejection: accept 8'hFF, then pulse `load` with 8'h00 at cycle 5 of the frame → frame still 1011_11111111; no second frame.
- Back-to-back: `load` held high with 8'h3C then 8'hC3 → two frames, acceptances exactly 14 cycles apart; second payload bits 1,1,0,0,0,0,1,1.
- Mid-frame reset: assert `rst` during payload bit 3 → `out`/`out_valid` drop asynchronously the same cycle; no `done`; next `load` produces a full frame from the sync bits.
- `GAP`=0, `DATA_W`=4 build: payload 4'h9 → `out`=1,0,1,1,1,0,0,1; `ready`=1 in the cycle after the last bit.
